// File: rtl/vmicro16_reset_pkg.sv
// Shared definitions for the vmicro16 reset/run sequencer: state encoding and
// elaboration-time helpers for latency and counter sizing.
package vmicro16_reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int MAX_CORES = 16;
    localparam int SYNC_STAGES = 2;

    // Clocks from external reset rising to running going high.
    function automatic int seq_latency(input int hold, input int cores, input int stagger);
        return SYNC_STAGES + hold + cores * stagger;
    endfunction

    // True when every value the shared counters must reach fits in cw bits.
    function automatic bit counter_fits(input int cw, input int hold, input int cores,
                                        input int stagger, input int run);
        int need;
        need = hold - 1;
        if (cores * stagger - 1 > need) need = cores * stagger - 1;
        if (run > need) need = run;
        return (cw >= 1) && (cw < 31) && (need < (1 << cw));
    endfunction

    function automatic bit params_ok(input int cores, input int hold, input int stagger,
                                     input int run, input int cw);
        return (cores >= 1) && (cores <= MAX_CORES) && (hold >= 1) && (stagger >= 1) &&
               (run >= 0) && counter_fits(cw, hold, cores, stagger, run);
    endfunction

endpackage

// File: rtl/vmicro16_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second
// rising clock edge after the external reset goes high.
module vmicro16_reset_sync (
    input  logic clk_i,
    input  logic arst_ni,
    output logic rst_sync_no
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_sync_no = sync_q[1];

endmodule

// File: rtl/vmicro16_reset_seq.sv
// Reset/run sequencer for the vmicro16 SoC: holds everything in reset, releases
// peripherals then each core in turn, and optionally enforces a run budget.
module vmicro16_reset_seq
    import vmicro16_reset_pkg::*;
#(
    parameter int CORES       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int RUN_CYCLES  = 0,
    parameter int CW          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_req,
    output logic [CORES-1:0] core_reset,
    output logic             periph_reset,
    output logic             running,
    output logic             timeout,
    output logic [CW-1:0]    cycle_count
);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST   = CW'(CORES * STAGGER - 1);
    localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);
    localparam bit            HAS_BUDGET = (RUN_CYCLES != 0);

    logic             rst_sync_n;
    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CORES-1:0] core_reset_q, core_reset_d;
    logic             periph_q, periph_d;
    logic             running_q, running_d;
    logic             timeout_q, timeout_d;

    vmicro16_reset_sync u_sync (
        .clk_i       (clk),
        .arst_ni     (reset),
        .rst_sync_no (rst_sync_n)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        count_d      = count_q;
        core_reset_d = core_reset_q;
        periph_d     = periph_q;
        running_d    = running_q;
        timeout_d    = timeout_q;

        if (soft_req) begin
            // Restart wins over everything, including a coincident timeout.
            state_d      = ST_ASSERT;
            cnt_d        = '0;
            count_d      = '0;
            core_reset_d = '1;
            periph_d     = 1'b1;
            running_d    = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        periph_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    cnt_d = cnt_q + CW'(1);
                    for (int k = 0; k < CORES; k++) begin
                        if (cnt_q == CW'((k + 1) * STAGGER - 1)) core_reset_d[k] = 1'b0;
                    end
                    if (cnt_q == REL_LAST) begin
                        state_d   = ST_RUN;
                        running_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (count_q != '1) count_d = count_q + CW'(1);
                    if (HAS_BUDGET && (count_q == RUN_LAST)) begin
                        state_d      = ST_DONE;
                        core_reset_d = '1;
                        running_d    = 1'b0;
                        timeout_d    = 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    // The synchronised reset clears state asynchronously, so pulling the board
    // reset low forces the reset values without waiting for a clock.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            count_q      <= '0;
            core_reset_q <= '1;
            periph_q     <= 1'b1;
            running_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            count_q      <= count_d;
            core_reset_q <= core_reset_d;
            periph_q     <= periph_d;
            running_q    <= running_d;
            timeout_q    <= timeout_d;
        end
    end

    assign core_reset   = core_reset_q;
    assign periph_reset = periph_q;
    assign running      = running_q;
    assign timeout      = timeout_q;
    assign cycle_count  = count_q;

endmodule

// File: doc/vmicro16_reset_seq.md
Name: vmicro16_reset_seq

Overview:
- Parametrised reset/run sequencer for the multi-core vmicro16 SoC. It replaces fixed "hold reset N clocks, run M clocks" bring-up with synthesizable logic.
- Synchronises the external reset, then holds the whole SoC in reset for a programmable time.
- Releases the peripheral/interconnect reset first, then each core in turn with a staggered delay.
- Optionally enforces a run-cycle budget (watchdog), after which all cores go back into reset and a timeout flag is raised.
- Sits between the board reset input and the per-core/peripheral reset nets of vmicro16_soc.

Parameters:
- CORES, 4, number of core reset outputs; must be 1..16.
- HOLD_CYCLES, 4, clocks all resets stay asserted after the synchronised reset release; must be ≥1.
- STAGGER, 2, clocks between successive releases (periph→core0, core0→core1, ...); must be ≥1.
- RUN_CYCLES, 0, run-cycle budget; 0 means unlimited (no timeout).
- CW, 16, width of the internal counters and of cycle_count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- soft_req  input  1  synchronous request to re-run the full sequence; acted on while high.
- core_reset  output  CORES  active-high reset per core; bit k drives core k.
- periph_reset  output  1  active-high reset for the interconnect and peripherals.
- running  output  1  high while all cores are out of reset and the budget has not expired.
- timeout  output  1  sticky flag: run budget expired.
- cycle_count  output  CW  clocks spent in RUN; saturates at 2^CW-1.

Behaviour:
- Reset synchroniser:
  - reset low asynchronously clears a 2-flop chain (rst_sync_n=0).
  - On deassertion, rst_sync_n goes high on the 2nd rising clk edge.
  - All state logic is held while rst_sync_n=0.
- Reset values (reset low, or rst_sync_n low): core_reset all 1s, periph_reset=1, running=0, timeout=0, cycle_count=0, state=ASSERT, internal counter=0.
- ASSERT:
  - Counter increments each clock.
  - On the edge where counter==HOLD_CYCLES-1: periph_reset<=0, counter<=0, state<=RELEASE.
- RELEASE:
  - Counter increments each clock.
  - Core k's reset deasserts on the edge ending the (k+1)*STAGGER-th clock after periph_reset fell.
  - On the edge releasing core CORES-1: state<=RUN and running<=1 on the same edge.
- RUN:
  - cycle_count increments each clock and saturates; it never wraps.
  - If RUN_CYCLES≠0, on the edge where cycle_count==RUN_CYCLES-1: state<=DONE, core_reset<=all 1s, running<=0, timeout<=1.
  - At that point cycle_count holds RUN_CYCLES.
- DONE:
  - All outputs hold; periph_reset stays 0 so that status can still be read.
  - Exit only via soft_req or reset.
- soft_req:
  - Sampled each edge in any state. On the next edge, core_reset<=all 1s, periph_reset<=1, running<=0, timeout<=0, cycle_count<=0, counter<=0, state<=ASSERT.
  - While soft_req stays high, the block remains in ASSERT with the counter held at 0.
  - soft_req has priority over the timeout transition on the same edge.
- Reset mid-sequence: asynchronous return to the reset values from any state.
- Outputs are registered; no combinational path from soft_req to any output.
- Total latency from reset rising to running=1: 2 + HOLD_CYCLES + CORES*STAGGER clocks.

Decomposition:
- Package vmicro16_reset_pkg holds:
  - state encoding (ASSERT, RELEASE, RUN, DONE, 2-bit);
  - localparam helpers for latency and counter-width checks.
- One natural sub-module: vmicro16_reset_sync. It is the 2-flop asynchronous-assert, synchronous-deassert synchroniser and is reusable by other reset domains.

Test Plan:
- Defaults; reset low 4 clocks then high → periph_reset falls 6 clocks after reset rises; core_reset[0..3] fall at +8, +10, +12, +14; running=1 at +14.
- RUN_CYCLES=10 → running=1 for exactly 10 clocks, then core_reset=4'hF, timeout=1, cycle_count=10, periph_reset stays 0.
- soft_req pulsed 1 clock while in RUN with cycle_count=5 → next edge all resets asserted, cycle_count=0; full release sequence repeats with the same timing as the first scenario, minus the 2 synchroniser clocks.
- soft_req held 3 clocks → sequence restarts from ASSERT after soft_req falls; soft_req and timeout on the same edge → ASSERT, timeout=0.
- reset pulled low during RELEASE (core0 released, core1 not) → all outputs return to reset values with no clock edge required.
- CW=4, RUN_CYCLES=0, run 40 clocks → cycle_count saturates at 15, running stays 1, timeout stays 0.
